// File: rtl/calculation.sv
// ============================================================================
//  Package     : calculation
//  Description : Shared types for calculation_unit and its controller.
//                Holds the select encoding, the op codes, the controller
//                state type and the op-to-select mapping.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package calculation;

    // Fraction/exponent routing inside calculation_unit
    typedef enum logic [2:0] {
        CALC_SEL_ADD  = 3'd0,
        CALC_SEL_SUB  = 3'd1,
        CALC_SEL_MUL  = 3'd2,
        CALC_SEL_DIV  = 3'd3,
        CALC_SEL_SQRT = 3'd4
    } calculation_select;

    typedef logic [2:0] calc_op_t;

    localparam calc_op_t OP_ADD  = 3'd0;
    localparam calc_op_t OP_SUB  = 3'd1;
    localparam calc_op_t OP_MUL  = 3'd2;
    localparam calc_op_t OP_DIV  = 3'd3;
    localparam calc_op_t OP_SQRT = 3'd4;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SINGLE     = 3'd1,
        DIV_START  = 3'd2,
        DIV_WAIT   = 3'd3,
        DIV_RESULT = 3'd4,
        DRAIN      = 3'd5
    } controller_state_t;

    // Illegal op codes fall back to the adder path; out_illegal flags them.
    function automatic calculation_select op_to_select(input calc_op_t op);
        calculation_select sel;
        case (op)
            OP_SUB:  sel = CALC_SEL_SUB;
            OP_MUL:  sel = CALC_SEL_MUL;
            OP_DIV:  sel = CALC_SEL_DIV;
            OP_SQRT: sel = CALC_SEL_SQRT;
            default: sel = CALC_SEL_ADD;
        endcase
        return sel;
    endfunction

endpackage

`default_nettype wire

// File: rtl/calculation_unit_watchdog.sv
// ============================================================================
//  Module      : calculation_unit_watchdog
//  Description : Saturating cycle counter guarding the divide/sqrt engine.
//                o_expired is high once the count reaches TIMEOUT_CYCLES-1.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module calculation_unit_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] c_LIMIT = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] c_MAX   = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] c_ONE   = CW'(1);

    logic [CW-1:0] r_count;

    // Clear wins over enable; the count parks at TIMEOUT_CYCLES instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != c_MAX)) begin
            r_count <= r_count + c_ONE;
        end
    end

    assign o_expired = (r_count >= c_LIMIT);

endmodule

`default_nettype wire

// File: rtl/calculation_unit_controller.sv
// ============================================================================
//  Module      : calculation_unit_controller
//  Description : Issue/result sequencer for calculation_unit. Single-cycle
//                ops stream at one per cycle; divide/sqrt are started on the
//                divider, tracked via busy/done and guarded by a watchdog.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module calculation_unit_controller #(
    parameter int TAG_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  calculation::calc_op_t         in_op,
    input  logic [TAG_WIDTH-1:0]          in_tag,
    output calculation::calculation_select calculation_select,
    output logic                          divider_mode,
    output logic                          divider_start,
    input  logic                          divider_busy,
    input  logic                          divider_done,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [TAG_WIDTH-1:0]          out_tag,
    output logic                          out_illegal,
    output logic                          out_timeout
);

    import calculation::*;

    controller_state_t              r_state;
    controller_state_t              w_state_next;
    calculation::calculation_select r_select;
    logic [TAG_WIDTH-1:0]           r_tag;
    logic                           r_mode;
    logic                           r_illegal;
    logic                           r_timeout;

    logic w_in_ready;
    logic w_accept;
    logic w_op_is_div;
    logic w_div_start;
    logic w_wd_clear;
    logic w_wd_enable;
    logic w_wd_expired;
    logic w_set_timeout;

    assign w_in_ready  = !flush && ((r_state == IDLE) || ((r_state == SINGLE) && out_ready));
    assign w_accept    = in_valid && w_in_ready;
    assign w_op_is_div = (in_op == OP_DIV) || (in_op == OP_SQRT);

    calculation_unit_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .rst_n     (reset),
        .i_clear   (w_wd_clear),
        .i_enable  (w_wd_enable),
        .o_expired (w_wd_expired)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and control decode; flush overrides every transition last
    always_comb begin
        w_state_next  = r_state;
        w_div_start   = 1'b0;
        w_wd_clear    = 1'b0;
        w_wd_enable   = 1'b0;
        w_set_timeout = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = w_op_is_div ? DIV_START : SINGLE;
                end
            end
            SINGLE: begin
                if (out_ready) begin
                    if (w_accept) begin
                        w_state_next = w_op_is_div ? DIV_START : SINGLE;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            DIV_START: begin
                if (!divider_busy) begin
                    w_div_start  = 1'b1;
                    w_wd_clear   = 1'b1;
                    w_state_next = DIV_WAIT;
                end
            end
            DIV_WAIT: begin
                w_wd_enable = 1'b1;
                if (divider_done) begin
                    w_state_next = DIV_RESULT;
                end else if (w_wd_expired) begin
                    w_set_timeout = 1'b1;
                    w_state_next  = DIV_RESULT;
                end
            end
            DIV_RESULT: begin
                if (out_ready) begin
                    w_state_next = r_timeout ? DRAIN : IDLE;
                end
            end
            DRAIN: begin
                if (!divider_busy) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        // A divider that may still be running must be drained so its late
        // done is never credited to the next op.
        if (flush) begin
            w_div_start   = 1'b0;
            w_set_timeout = 1'b0;
            if ((r_state == DIV_START) || (r_state == DIV_WAIT) || (r_state == DRAIN)) begin
                w_state_next = DRAIN;
            end else begin
                w_state_next = IDLE;
            end
        end
    end

    // Op context captured on accept; held stable until the next accept
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tag     <= '0;
            r_select  <= CALC_SEL_ADD;
            r_mode    <= 1'b0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
        end else if (w_accept) begin
            r_tag     <= in_tag;
            r_select  <= op_to_select(in_op);
            r_mode    <= (in_op == OP_SQRT);
            r_illegal <= (in_op > OP_SQRT);
            r_timeout <= 1'b0;
        end else if (w_set_timeout) begin
            r_timeout <= 1'b1;
        end
    end

    assign in_ready           = w_in_ready;
    assign divider_start      = w_div_start;
    assign divider_mode       = r_mode;
    assign calculation_select = r_select;
    assign out_tag            = r_tag;
    assign out_valid          = (r_state == SINGLE) || (r_state == DIV_RESULT);
    assign out_illegal        = out_valid && r_illegal;
    assign out_timeout        = out_valid && r_timeout;

endmodule

`default_nettype wire

// File: doc/calculation_unit_controller.md
Name: calculation_unit_controller

Overview:
Sequencer in front of calculation_unit. Accepts one operation per handshake from issue logic and drives calculation_select, divider_mode and divider_start. Tracks the multi-cycle divide/sqrt engine via busy/done and presents a valid/ready result handshake to the normalise/round stage. Also provides flush and a hang watchdog for the divider.

Parameters:
TAG_WIDTH, 4, width of the opaque op tag passed from issue to result
TIMEOUT_CYCLES, 64, max cycles in DIV_WAIT before done must arrive; range 2..1023

Ports:
clk  input  1  clock; all state updates on its rising edge
reset  input  1  asynchronous, active-low reset
flush  input  1  synchronous abort of any in-flight op
in_valid  input  1  issue stage has an op
in_ready  output  1  controller accepts op this cycle
in_op  input  3  0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 SQRT, 5-7 illegal
in_tag  input  TAG_WIDTH  tag captured with the op
calculation_select  output  calculation::calculation_select  fraction/exponent select to calculation_unit
divider_mode  output  1  0 divide, 1 sqrt
divider_start  output  1  one-cycle start pulse to divider
divider_busy  input  1  divider busy
divider_done  input  1  divider done pulse
out_valid  output  1  calculated_exponent/fraction valid for current op
out_ready  input  1  downstream consumes result
out_tag  output  TAG_WIDTH  tag of presented result
out_illegal  output  1  qualifies out_valid; op code was 5-7
out_timeout  output  1  qualifies out_valid; divider watchdog expired

Behaviour:
- Reset values: state IDLE, in_ready 1, out_valid 0, divider_start 0, divider_mode 0, calculation_select ADD, out_tag 0, out_illegal 0, out_timeout 0, watchdog count 0.
- States: IDLE, SINGLE, DIV_START, DIV_WAIT, DIV_RESULT, DRAIN.
- Accept means in_valid && in_ready. On accept, register op, tag, select and mode.
- in_ready = (IDLE) || (SINGLE && out_ready). It is 0 in all other states and whenever flush=1.
- IDLE:
  - Accept ADD/SUB/MUL/illegal -> SINGLE.
  - Accept DIV/SQRT -> DIV_START.
  - Illegal ops drive select ADD.
- SINGLE:
  - out_valid=1 with out_illegal set for op 5-7. Latency is 1 cycle from accept.
  - out_ready with a new accept -> SINGLE or DIV_START per the new op. This gives back-to-back single ops at 1/cycle.
  - out_ready with no accept -> IDLE.
  - Otherwise hold. Select and tag stay stable while out_valid && !out_ready.
- DIV_START:
  - If divider_busy=0: divider_start=1 for exactly one cycle, then -> DIV_WAIT and clear the watchdog.
  - If divider_busy=1: hold without asserting start.
- DIV_WAIT:
  - The watchdog increments each cycle.
  - divider_done -> DIV_RESULT. done wins if it coincides with expiry.
  - Count reaching TIMEOUT_CYCLES-1 without done -> DIV_RESULT with out_timeout=1, then DRAIN after handshake.
- DIV_RESULT:
  - out_valid=1. Select and mode are held, so the divider's quotient/root stays routed to calculated_fraction.
  - out_ready -> IDLE, or -> DRAIN if timeout.
  - Never accepts in the same cycle. Divide throughput is bounded by the divider anyway.
- DRAIN:
  - Wait until divider_busy=0, then -> IDLE.
  - Any divider_done seen here is ignored.
- flush has priority over every transition:
  - From DIV_START (start already pulsed or not), DIV_WAIT or DRAIN -> DRAIN, so a stale done cannot be credited to the next op.
  - From other states -> IDLE.
  - out_valid and divider_start are 0 in the cycle after flush. divider_start is also suppressed in the flush cycle itself.
- divider_done outside DIV_WAIT/DRAIN is ignored. A sticky debug bit is not required.
- Reset asserted mid-operation returns all state to reset values immediately. Reset of the divider is the system's responsibility.
- Watchdog width is $clog2(TIMEOUT_CYCLES+1). It saturates, never wraps.

Decomposition:
- Package calculation (existing) gains: op code localparams OP_ADD..OP_SQRT, typedef calc_op_t (3 bits), typedef controller_state_t enum, and function op_to_select(calc_op_t) returning calculation_select.
- One sub-module: calculation_unit_watchdog. It contains the clear/enable saturating counter and the expired output. The FSM stays in the top module.

Test Plan:
- ADD, then MUL on the next cycle, out_ready held 1 -> out_valid on cycles 1 and 2, tags 3 and 4, in_ready stays 1, select ADD then MUL.
- SUB with out_ready=0 for 3 cycles -> out_valid, select SUB and tag held stable 3 cycles, in_ready=0, released on out_ready.
- DIV with divider model done 27 cycles after start -> one-cycle divider_start, divider_mode=0, out_valid only after done, in_ready=0 throughout, returns to IDLE.
- SQRT with a model that never asserts done, TIMEOUT_CYCLES=8 -> out_valid with out_timeout=1 after 8 cycles in DIV_WAIT, then DRAIN until busy drops, then in_ready=1.
- Flush 5 cycles after DIV start, late done at cycle 20, new ADD offered -> ADD not accepted until busy=0, late done ignored, ADD result's tag is correct.
- Op 6, then async reset asserted during DIV_WAIT -> out_valid with out_illegal=1; reset clears out_valid/start immediately, state IDLE.
